// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU and the block memory.
// CPU word accesses hit combinationally in IDLE. A miss writes back a dirty victim if needed,
// then refills the whole block and returns to IDLE, where the held request hits.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------------
//   S_IDLE    | serve hits; on a miss latch {tag,idx} and choose writeback/refill
//   S_WRITEBACK | drive victim block to memory until m_write_done_i
//   S_REFILL  | request the missing block until m_read_done_i, then install it
module dcache #(
    parameter int c_block_size = 2,
    parameter int c_line_size  = 32,
    parameter int address_size = 32,
    parameter int c_index_size = 3
) (
    input  logic                                        c_clk_i,
    input  logic                                        c_reset_n_i,
    input  logic                                        c_read_i,
    input  logic                                        c_write_i,
    input  logic [address_size-1:0]                     c_addr_i,
    input  logic [c_line_size-1:0]                      c_wr_data_i,
    output logic [c_line_size-1:0]                      c_read_data_o,
    output logic                                        c_busywait_o,
    output logic                                        m_read_o,
    output logic                                        m_wr_o,
    output logic [address_size-c_block_size-3:0]        m_addr_o,
    output logic [(2**c_block_size)*c_line_size-1:0]    m_wr_data_o,
    input  logic [(2**c_block_size)*c_line_size-1:0]    m_read_data_i,
    input  logic                                        m_busywait_i,
    input  logic                                        m_read_done_i,
    input  logic                                        m_write_done_i
);

    localparam int TAG_W = address_size - c_index_size - c_block_size - 2;
    localparam int BLK_W = (2**c_block_size) * c_line_size;
    localparam int LINES = 2**c_index_size;
    localparam int IDX_LSB = c_block_size + 2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]        valid_q;
    logic [LINES-1:0]        dirty_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [BLK_W-1:0]        data_q [LINES];

    logic [c_index_size-1:0] miss_idx_q;
    logic [TAG_W-1:0]        miss_tag_q;

    logic [c_block_size-1:0] c_word;
    logic [c_index_size-1:0] c_idx;
    logic [TAG_W-1:0]        c_tag;
    logic                    c_req;
    logic                    hit;
    logic [c_line_size-1:0]  hit_word;

    logic                    wr_hit;
    logic                    start_miss;
    logic                    wb_done;
    logic                    fill;

    // Memory busy is informational only; the byte offset never selects anything.
    logic unused_inputs;
    assign unused_inputs = ^{m_busywait_i, c_addr_i[1:0]};

    assign c_word   = c_addr_i[IDX_LSB-1:2];
    assign c_idx    = c_addr_i[IDX_LSB +: c_index_size];
    assign c_tag    = c_addr_i[address_size-1 -: TAG_W];
    assign c_req    = c_read_i | c_write_i;
    assign hit      = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
    assign hit_word = data_q[c_idx][c_word*c_line_size +: c_line_size];

    // Next-state and output decode; memory-side outputs depend on state only.
    always_comb begin
        state_d       = state_q;
        c_busywait_o  = 1'b0;
        c_read_data_o = '0;
        m_read_o      = 1'b0;
        m_wr_o        = 1'b0;
        m_addr_o      = '0;
        m_wr_data_o   = '0;
        wr_hit        = 1'b0;
        start_miss    = 1'b0;
        wb_done       = 1'b0;
        fill          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (c_req) begin
                    if (hit) begin
                        // Write wins when both requests are raised together.
                        wr_hit = c_write_i;
                        if (c_read_i) begin
                            c_read_data_o = hit_word;
                        end
                    end else begin
                        c_busywait_o = 1'b1;
                        start_miss   = 1'b1;
                        if (valid_q[c_idx] && dirty_q[c_idx]) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            state_d = S_REFILL;
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                c_busywait_o = 1'b1;
                m_wr_o       = 1'b1;
                m_addr_o     = {tag_q[miss_idx_q], miss_idx_q};
                m_wr_data_o  = data_q[miss_idx_q];
                if (m_write_done_i) begin
                    wb_done = 1'b1;
                    // An abandoned request has no use for the refill.
                    state_d = c_req ? S_REFILL : S_IDLE;
                end
            end
            S_REFILL: begin
                c_busywait_o = 1'b1;
                m_read_o     = 1'b1;
                m_addr_o     = {miss_tag_q, miss_idx_q};
                if (m_read_done_i) begin
                    fill    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, line status bits and the latched miss address.
    always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
        if (!c_reset_n_i) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_miss) begin
                miss_idx_q <= c_idx;
                miss_tag_q <= c_tag;
            end
            if (wr_hit) begin
                dirty_q[c_idx] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[miss_idx_q] <= 1'b0;
            end
            if (fill) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays need no reset; valid_q guards their contents.
    always_ff @(posedge c_clk_i) begin
        if (fill) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= m_read_data_i;
        end else if (wr_hit) begin
            data_q[c_idx][c_word*c_line_size +: c_line_size] <= c_wr_data_i;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a behavioural block memory: each transfer is seen one
// cycle after the request rises, runs four busy cycles, and ends with a one-cycle done pulse.
module tb_dcache;

    logic          c_clk_i     = 1'b0;
    logic          c_reset_n_i = 1'b0;
    logic          c_read_i    = 1'b0;
    logic          c_write_i   = 1'b0;
    logic [31:0]   c_addr_i    = '0;
    logic [31:0]   c_wr_data_i = '0;
    logic [31:0]   c_read_data_o;
    logic          c_busywait_o;
    logic          m_read_o;
    logic          m_wr_o;
    logic [27:0]   m_addr_o;
    logic [127:0]  m_wr_data_o;
    logic [127:0]  m_read_data_i;
    logic          m_busywait_i;
    logic          m_read_done_i;
    logic          m_write_done_i;

    int n_vec = 0;
    int n_err = 0;

    dcache dut (
        .c_clk_i        (c_clk_i),
        .c_reset_n_i    (c_reset_n_i),
        .c_read_i       (c_read_i),
        .c_write_i      (c_write_i),
        .c_addr_i       (c_addr_i),
        .c_wr_data_i    (c_wr_data_i),
        .c_read_data_o  (c_read_data_o),
        .c_busywait_o   (c_busywait_o),
        .m_read_o       (m_read_o),
        .m_wr_o         (m_wr_o),
        .m_addr_o       (m_addr_o),
        .m_wr_data_o    (m_wr_data_o),
        .m_read_data_i  (m_read_data_i),
        .m_busywait_i   (m_busywait_i),
        .m_read_done_i  (m_read_done_i),
        .m_write_done_i (m_write_done_i)
    );

    always #5 c_clk_i = ~c_clk_i;

    // Block memory model; contents survive reset, word w initialised to {16'hC0DE, w}.
    logic [127:0] mem [64];
    logic         mem_inited = 1'b0;
    logic         mem_busy;
    int           mem_cnt;
    logic         mem_op_wr;
    logic [5:0]   mem_blk;
    logic [127:0] mem_wdata;

    always @(posedge c_clk_i or negedge c_reset_n_i) begin
        if (!c_reset_n_i) begin
            if (!mem_inited) begin
                for (int b = 0; b < 64; b++) begin
                    for (int j = 0; j < 4; j++) begin
                        mem[b][j*32 +: 32] = {16'hC0DE, 16'(b*4 + j)};
                    end
                end
                mem_inited = 1'b1;
            end
            m_read_done_i  = 1'b0;
            m_write_done_i = 1'b0;
            m_busywait_i   = 1'b0;
            m_read_data_i  = '0;
            mem_busy       = 1'b0;
            mem_cnt        = 0;
        end else begin
            #1;
            m_read_done_i  = 1'b0;
            m_write_done_i = 1'b0;
            if (mem_busy) begin
                mem_cnt++;
                if (mem_cnt == 5) begin
                    mem_busy     = 1'b0;
                    m_busywait_i = 1'b0;
                    if (mem_op_wr) begin
                        mem[mem_blk]   = mem_wdata;
                        m_write_done_i = 1'b1;
                    end else begin
                        m_read_data_i = mem[mem_blk];
                        m_read_done_i = 1'b1;
                    end
                end
            end else if (m_read_o || m_wr_o) begin
                mem_busy     = 1'b1;
                mem_cnt      = 0;
                m_busywait_i = 1'b1;
                mem_op_wr    = m_wr_o;
                mem_blk      = m_addr_o[5:0];
                mem_wdata    = m_wr_data_o;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_busy;
        int          exp_rdc;
        int          exp_wrc;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [19];

    // Hold one request until busywait falls; count stall and memory-request cycles.
    task automatic run_vec(input vec_t v);
        int nb;
        int nr;
        int nw;
        @(posedge c_clk_i); #2;
        c_read_i    = v.rd;
        c_write_i   = v.wr;
        c_addr_i    = v.addr;
        c_wr_data_i = v.wdata;
        nb = 0; nr = 0; nw = 0;
        @(negedge c_clk_i);
        while (c_busywait_o && nb < 100) begin
            nb++;
            if (m_read_o) nr++;
            if (m_wr_o) nw++;
            @(negedge c_clk_i);
        end
        chk({v.name, "_busy_cycles"}, 128'(nb), 128'(v.exp_busy));
        chk({v.name, "_mem_rd_cycles"}, 128'(nr), 128'(v.exp_rdc));
        chk({v.name, "_mem_wr_cycles"}, 128'(nw), 128'(v.exp_wrc));
        if (v.chk_data) begin
            chk({v.name, "_rdata"}, 128'(c_read_data_o), 128'(v.exp_data));
        end
        @(posedge c_clk_i); #2;
        c_read_i  = 1'b0;
        c_write_i = 1'b0;
    endtask

    initial begin
        int          nb;
        int          nw;
        int          wb_bad;
        logic        seen_rd;
        logic        seen_wr;
        logic [127:0] victim;

        //          name        rd    wr    addr          wdata         bsy rd wr chk   data
        vecs[0]  = '{"rd40",    1'b1, 1'b0, 32'h0000_0040, 32'h0,        7, 6, 0, 1'b1, 32'hC0DE_0010};
        vecs[1]  = '{"wr44",    1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 0, 0, 1'b1, 32'h0};
        vecs[2]  = '{"rd44",    1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 0, 0, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{"rd48",    1'b1, 1'b0, 32'h0000_0048, 32'h0,        0, 0, 0, 1'b1, 32'hC0DE_0012};
        vecs[4]  = '{"wrmiss80",1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 7, 6, 0, 1'b1, 32'h0};
        vecs[5]  = '{"rd80",    1'b1, 1'b0, 32'h0000_0080, 32'h0,        0, 0, 0, 1'b1, 32'h1234_5678};
        vecs[6]  = '{"rd84",    1'b1, 1'b0, 32'h0000_0084, 32'h0,        0, 0, 0, 1'b1, 32'hC0DE_0021};
        vecs[7]  = '{"rd8c",    1'b1, 1'b0, 32'h0000_008C, 32'h0,        0, 0, 0, 1'b1, 32'hC0DE_0023};
        vecs[8]  = '{"rdwr4c",  1'b1, 1'b1, 32'h0000_004C, 32'hCAFE_F00D, 0, 0, 0, 1'b0, 32'h0};
        vecs[9]  = '{"rd4c",    1'b1, 1'b0, 32'h0000_004C, 32'h0,        0, 0, 0, 1'b1, 32'hCAFE_F00D};
        vecs[10] = '{"rd44_wb", 1'b1, 1'b0, 32'h0000_0044, 32'h0,        7, 6, 0, 1'b1, 32'hDEAD_BEEF};
        vecs[11] = '{"rd4c_wb", 1'b1, 1'b0, 32'h0000_004C, 32'h0,        0, 0, 0, 1'b1, 32'hCAFE_F00D};
        vecs[12] = '{"rd40_b",  1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 0, 0, 1'b1, 32'hC0DE_0010};
        vecs[13] = '{"wr48",    1'b0, 1'b1, 32'h0000_0048, 32'h1111_2222, 0, 0, 0, 1'b1, 32'h0};
        vecs[14] = '{"rd148",   1'b1, 1'b0, 32'h0000_0148, 32'h0,       13, 6, 6, 1'b1, 32'hC0DE_0052};
        vecs[15] = '{"rd48_wb", 1'b1, 1'b0, 32'h0000_0048, 32'h0,        7, 6, 0, 1'b1, 32'h1111_2222};
        vecs[16] = '{"rd50_rst",1'b1, 1'b0, 32'h0000_0050, 32'h0,        7, 6, 0, 1'b1, 32'hC0DE_0014};
        vecs[17] = '{"rd44_rst",1'b1, 1'b0, 32'h0000_0044, 32'h0,        7, 6, 0, 1'b1, 32'hDEAD_BEEF};
        vecs[18] = '{"rd80_rst",1'b1, 1'b0, 32'h0000_0080, 32'h0,        7, 6, 0, 1'b1, 32'hC0DE_0020};

        // Reset values
        repeat (2) @(posedge c_clk_i);
        @(negedge c_clk_i);
        chk("rst_busywait", 128'(c_busywait_o), 128'(0));
        chk("rst_m_read", 128'(m_read_o), 128'(0));
        chk("rst_m_wr", 128'(m_wr_o), 128'(0));
        chk("rst_m_addr", 128'(m_addr_o), 128'(0));
        chk("rst_m_wr_data", m_wr_data_o, 128'(0));
        chk("rst_rdata", 128'(c_read_data_o), 128'(0));
        c_reset_n_i = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Dirty victim: writeback of line 4 (tag 0) then refill of block 0x14
        victim = {32'hCAFE_F00D, 32'hC0DE_0012, 32'hDEAD_BEEF, 32'hC0DE_0010};
        @(posedge c_clk_i); #2;
        c_read_i = 1'b1;
        c_addr_i = 32'h0000_0140;
        nb = 0; nw = 0; wb_bad = 0; seen_rd = 1'b0; seen_wr = 1'b0;
        @(negedge c_clk_i);
        while (c_busywait_o && nb < 100) begin
            nb++;
            if (m_wr_o) begin
                nw++;
                if (m_addr_o !== 28'h4 || m_wr_data_o !== victim || m_read_o) wb_bad++;
                if (!seen_wr) begin
                    seen_wr = 1'b1;
                    chk("t3_wb_addr", 128'(m_addr_o), 128'(28'h4));
                    chk("t3_wb_word1", 128'(m_wr_data_o[63:32]), 128'(32'hDEAD_BEEF));
                end
            end
            if (m_read_o && !seen_rd) begin
                seen_rd = 1'b1;
                chk("t3_refill_addr", 128'(m_addr_o), 128'(28'h14));
                chk("t3_refill_after_wb", 128'(nw), 128'(6));
            end
            @(negedge c_clk_i);
        end
        chk("t3_busy_cycles", 128'(nb), 128'(13));
        chk("t3_wb_stable", 128'(wb_bad), 128'(0));
        chk("t3_refill_seen", 128'(seen_rd), 128'(1));
        chk("t3_rdata", 128'(c_read_data_o), 128'(32'hC0DE_0050));
        @(posedge c_clk_i); #2;
        c_read_i = 1'b0;

        for (int i = 10; i < 16; i++) run_vec(vecs[i]);

        // Reset during refill: requests drop at once, line is forgotten
        @(posedge c_clk_i); #2;
        c_read_i = 1'b1;
        c_addr_i = 32'h0000_0050;
        repeat (3) @(negedge c_clk_i);
        chk("t5_in_refill", 128'(m_read_o), 128'(1));
        #2;
        c_reset_n_i = 1'b0;
        c_read_i    = 1'b0;
        #1;
        chk("t5_rst_m_read", 128'(m_read_o), 128'(0));
        chk("t5_rst_busywait", 128'(c_busywait_o), 128'(0));
        chk("t5_rst_m_addr", 128'(m_addr_o), 128'(0));
        @(negedge c_clk_i);
        c_reset_n_i = 1'b1;

        for (int i = 16; i < 19; i++) run_vec(vecs[i]);

        repeat (2) @(posedge c_clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
